// File: rtl/debounce_repeat_n.sv
// N-channel switch/button debouncer with rise/fall strobes and per-channel auto-repeat.
// Each channel has a 2-flop synchroniser, a stability counter, and (when masked in) a repeat FSM.
module debounce_repeat_n #(
    parameter int                N_CH     = 9,
    parameter int                DB_CNT   = 1_000_000,
    parameter int                RPT_DLY  = 50_000_000,
    parameter int                RPT_PER  = 10_000_000,
    parameter logic [N_CH-1:0]   RPT_MASK = 9'h1F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] rpt_pulse,
    output logic            any_active
);

    localparam int CW      = (DB_CNT > 1) ? $clog2(DB_CNT + 1) : 1;
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_DELAY  = 2'd1;
    localparam logic [1:0] R_REPEAT = 2'd2;

    logic [N_CH-1:0] db_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          s1, s2, lvl, rise_q, fall_q;
        logic [CW-1:0] cnt;
        logic          accept, lvl_nxt, rise_nxt, fall_nxt;

        // The counter only advances while the synchronised input disagrees with the accepted level
        assign accept   = (s2 != lvl) && (cnt == DB_LAST);
        assign lvl_nxt  = accept ? s2 : lvl;
        assign rise_nxt = accept & s2;
        assign fall_nxt = accept & ~s2;
        assign db_nxt[i] = lvl_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                lvl    <= 1'b0;
                cnt    <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                s1     <= in_raw[i];
                s2     <= s1;
                lvl    <= lvl_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
                if (s2 == lvl || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign db_level[i]   = lvl;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;

        if (RPT_MASK[i]) begin : g_rpt
            logic [1:0]    state;
            logic [RW-1:0] rcnt;
            logic          rpt_q;

            // A release always returns to idle, even if a repeat was due on the same edge
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state <= R_IDLE;
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (fall_nxt) begin
                        state <= R_IDLE;
                        rcnt  <= '0;
                    end else begin
                        case (state)
                            R_IDLE: begin
                                if (rise_nxt) begin
                                    rpt_q <= 1'b1;
                                    rcnt  <= '0;
                                    state <= R_DELAY;
                                end
                            end
                            R_DELAY: begin
                                if (rcnt == DLY_LAST) begin
                                    rpt_q <= 1'b1;
                                    rcnt  <= '0;
                                    state <= R_REPEAT;
                                end else begin
                                    rcnt <= rcnt + RW'(1);
                                end
                            end
                            R_REPEAT: begin
                                if (rcnt == PER_LAST) begin
                                    rpt_q <= 1'b1;
                                    rcnt  <= '0;
                                end else begin
                                    rcnt <= rcnt + RW'(1);
                                end
                            end
                            default: begin
                                state <= R_IDLE;
                                rcnt  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign rpt_pulse[i] = rpt_q;
        end else begin : g_norpt
            assign rpt_pulse[i] = rise_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_active <= 1'b0;
        end else begin
            any_active <= |db_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_repeat_n.sv
// Directed bench for debounce_repeat_n with small counts (DB_CNT=4, RPT_DLY=20, RPT_PER=5, mask 3'b110).
// Edge numbers count posedges after the input change; outputs are sampled 1 time unit after each edge.
module tb_debounce_repeat_n;

    localparam int N_CH = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] in_raw;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] rpt_pulse;
    logic            any_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_repeat_n #(
        .N_CH     (3),
        .DB_CNT   (4),
        .RPT_DLY  (20),
        .RPT_PER  (5),
        .RPT_MASK (3'b110)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_raw     (in_raw),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .rpt_pulse  (rpt_pulse),
        .any_active (any_active)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        in_raw = '0;
        repeat (30) tick();
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        in_raw = '0;
        #3;
        checks++;
        if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !== 13'd0) begin
            errors++;
            $display("FAIL reset_initial: db=%b rise=%b fall=%b rpt=%b any=%b, required all zero",
                     db_level, rise_pulse, fall_pulse, rpt_pulse, any_active);
        end
        repeat (2) tick();
        checks++;
        if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !== 13'd0) begin
            errors++;
            $display("FAIL reset_clocked: db=%b rise=%b fall=%b rpt=%b any=%b, required all zero",
                     db_level, rise_pulse, fall_pulse, rpt_pulse, any_active);
        end
        reset = 1'b1;
    endtask

    task automatic test_clean_press;
        logic [2:0] e_db, e_rise, e_rpt;
        in_raw = 3'b001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            e_db   = {2'b00, (e >= 6)};
            e_rise = {2'b00, (e == 6)};
            e_rpt  = e_rise;
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, 3'b000, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL clean_press edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=000 rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    task automatic test_bounce;
        logic [2:0] e_db, e_rise, e_rpt;
        for (int e = 1; e <= 40; e++) begin
            if (e <= 30) in_raw[0] = (((e - 1) / 3) % 2 == 0);
            else         in_raw[0] = 1'b1;
            tick();
            e_db   = {2'b00, (e >= 36)};
            e_rise = {2'b00, (e == 36)};
            e_rpt  = e_rise;
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, 3'b000, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL bounce edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=000 rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    task automatic test_hold_repeat;
        logic [2:0] e_db, e_rise, e_fall, e_rpt;
        in_raw = 3'b010;
        for (int e = 1; e <= 60; e++) begin
            if (e == 46) in_raw[1] = 1'b0;
            tick();
            e_db   = {1'b0, (e >= 6 && e < 51), 1'b0};
            e_rise = {1'b0, (e == 6), 1'b0};
            e_fall = {1'b0, (e == 51), 1'b0};
            e_rpt  = {1'b0, (e == 6 || e == 26 || e == 31 || e == 36 || e == 41 || e == 46), 1'b0};
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, e_fall, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL hold_repeat edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=%b rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_fall, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    task automatic test_release_wins;
        logic [2:0] e_db, e_rise, e_fall, e_rpt;
        in_raw = 3'b100;
        for (int e = 1; e <= 75; e++) begin
            if (e == 26) in_raw[2] = 1'b0;
            if (e == 46) in_raw[2] = 1'b1;
            tick();
            e_db   = {((e >= 6 && e < 31) || e >= 51), 2'b00};
            e_rise = {(e == 6 || e == 51), 2'b00};
            e_fall = {(e == 31), 2'b00};
            e_rpt  = {(e == 6 || e == 26 || e == 51 || e == 71), 2'b00};
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, e_fall, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL release_wins edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=%b rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_fall, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous;
        logic [2:0] e_db, e_rise, e_fall, e_rpt;
        in_raw = 3'b011;
        for (int e = 1; e <= 60; e++) begin
            if (e == 41) in_raw[0] = 1'b0;
            if (e == 46) in_raw[1] = 1'b0;
            tick();
            e_db   = {1'b0, (e >= 6 && e < 51), (e >= 6 && e < 46)};
            e_rise = {1'b0, (e == 6), (e == 6)};
            e_fall = {1'b0, (e == 51), (e == 46)};
            e_rpt  = {1'b0, (e == 6 || e == 26 || e == 31 || e == 36 || e == 41 || e == 46), (e == 6)};
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, e_fall, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL simultaneous edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=%b rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_fall, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_hold;
        logic [2:0] e_db, e_rise, e_rpt;
        in_raw = 3'b010;
        for (int e = 1; e <= 30; e++) begin
            tick();
            e_db  = {1'b0, (e >= 6), 1'b0};
            e_rpt = {1'b0, (e == 6 || e == 26), 1'b0};
            checks++;
            if ({db_level, rpt_pulse} !== {e_db, e_rpt}) begin
                errors++;
                $display("FAIL pre_reset_hold edge %0d: db=%b rpt=%b, required db=%b rpt=%b",
                         e, db_level, rpt_pulse, e_db, e_rpt);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: db=%b rise=%b fall=%b rpt=%b any=%b, required all zero",
                     db_level, rise_pulse, fall_pulse, rpt_pulse, any_active);
        end
        repeat (2) tick();
        checks++;
        if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !== 13'd0) begin
            errors++;
            $display("FAIL reset_held: db=%b rise=%b fall=%b rpt=%b any=%b, required all zero",
                     db_level, rise_pulse, fall_pulse, rpt_pulse, any_active);
        end
        reset = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            e_db   = {1'b0, (e >= 6), 1'b0};
            e_rise = {1'b0, (e == 6), 1'b0};
            e_rpt  = {1'b0, (e == 6 || e == 26 || e == 31), 1'b0};
            checks++;
            if ({db_level, rise_pulse, fall_pulse, rpt_pulse, any_active} !==
                {e_db, e_rise, 3'b000, e_rpt, |e_db}) begin
                errors++;
                $display("FAIL after_reset edge %0d: db=%b rise=%b fall=%b rpt=%b any=%b, required db=%b rise=%b fall=000 rpt=%b any=%b",
                         e, db_level, rise_pulse, fall_pulse, rpt_pulse, any_active, e_db, e_rise, e_rpt, |e_db);
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_release_wins();
        test_simultaneous();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
